// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between execute-stage control and the data-memory responder
interface dmem_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WData;
    logic [DATA_W-1:0] MDRdata;
    logic              Done;
    logic              Stall;
    logic              BadReq;

    modport master (
        output MemRead, MemWrite, Addr, WData,
        input  MDRdata, Done, Stall, BadReq
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WData,
        output MDRdata, Done, Stall, BadReq
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data store with programmable wait states, pipeline stall and done strobe
module dmem_responder #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input logic   clock,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              stall_q, stall_d;
    logic              bad_q, bad_d;
    logic              fire;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    // With zero wait states the access uses the live request; otherwise the latched one.
    assign acc_we    = (state_q == BUSY) ? we_q    : bus.MemWrite;
    assign acc_addr  = (state_q == BUSY) ? addr_q  : bus.Addr;
    assign acc_wdata = (state_q == BUSY) ? wdata_q : bus.WData;

    // Next-state, request acceptance and the registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        done_d  = 1'b0;
        stall_d = 1'b0;
        bad_d   = 1'b0;
        fire    = 1'b0;
        if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                fire    = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                stall_d = 1'b1;
            end
        end else if (bus.MemRead && bus.MemWrite) begin
            bad_d   = 1'b1;
            state_d = IDLE;
        end else if (bus.MemRead || bus.MemWrite) begin
            addr_d  = bus.Addr;
            wdata_d = bus.WData;
            we_d    = bus.MemWrite;
            if (WAIT_CYCLES == 0) begin
                fire    = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d   = CNT_W'(WAIT_CYCLES);
                stall_d = 1'b1;
                state_d = BUSY;
            end
        end else begin
            state_d = IDLE;
        end
        mdr_d = (fire && !acc_we) ? mem[acc_addr] : mdr_q;
    end

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            mdr_q   <= mdr_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            bad_q   <= bad_d;
        end
    end

    // Store write port; contents survive reset, but nothing commits while reset is held.
    always_ff @(posedge clock) begin
        if (fire && acc_we && !reset) mem[acc_addr] <= acc_wdata;
    end

    assign bus.MDRdata = mdr_q;
    assign bus.Done    = done_q;
    assign bus.Stall   = stall_q;
    assign bus.BadReq  = bad_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 8-bit pipelined processor. It services the MemRead/MemWrite requests raised by the execute-stage control, holds a word-addressed data store, and inserts a programmable number of wait states. It drives a Stall to freeze the pipeline while busy and returns read data to the MDR with a one-cycle Done strobe.

## Interface
- DATA_W, 8, data word width
- ADDR_W, 8, address width; store depth is 2^ADDR_W words
- WAIT_CYCLES, 2, wait states per access (0 allowed)

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- MemRead  input  1  read request from execute stage (level)
- MemWrite  input  1  write request from execute stage (level)
- Addr  input  ADDR_W  access address, sampled on acceptance
- WData  input  DATA_W  write data, sampled on acceptance
- MDRdata  output  DATA_W  read data for MDR load
- Done  output  1  one-cycle strobe: access completed
- Stall  output  1  pipeline freeze while an access is in progress
- BadReq  output  1  one-cycle strobe: MemRead and MemWrite both high

## Operation
- One clock, one asynchronous active-high reset; all outputs registered.
- States: IDLE, BUSY, DONE. Internal wait counter, width max(1, clog2(WAIT_CYCLES+1)).
- Accept condition: state IDLE or DONE, exactly one of MemRead/MemWrite high at the clock edge. Addr, WData and operation latched.
- Both MemRead and MemWrite high in IDLE/DONE: no access, BadReq=1 for the next cycle, state goes to IDLE.
- WAIT_CYCLES>=1: accept -> BUSY, counter=WAIT_CYCLES, Stall=1. Each edge in BUSY decrements the counter. The edge where the counter equals 1 performs the access: a write updates store[Addr]; a read loads MDRdata=store[Addr]. That edge moves to DONE with Stall=0 and Done=1.
- WAIT_CYCLES=0: the access is performed on the accept edge, the state moves directly to DONE, and Stall is never asserted.
- DONE lasts one cycle (Done=1). On the next edge the block accepts a new request if one is present; otherwise it returns to IDLE with Done=0.
- Requests present while in BUSY are ignored and not queued. The requester holds its level; that level is re-sampled on the DONE/IDLE edge.
- MDRdata holds its last read value until the next read completes. Writes do not change MDRdata.
- Store contents are not reset. The store is sized to the full address space, so there is no out-of-range case.

## Timing
- Reset values: state IDLE, Stall=0, Done=0, BadReq=0, MDRdata=0, counter=0.
- Latency: request accepted at edge k. Stall is high during cycles k..k+W-1 (W=WAIT_CYCLES). Done and valid MDRdata appear after edge k+W.
- Back-to-back: the next request can be accepted at edge k+W+1, which is the DONE cycle's edge. Sustained throughput is one access per W+1 cycles.
- Read-after-write to the same address returns the new data. The write commits before the following access is accepted.
- Reset mid-access aborts immediately: Stall and Done drop asynchronously, and a pending write is not committed. Earlier store contents are preserved.
- Done, BadReq: exactly one cycle wide each.

## Test plan
- W=2: write 0x5A to Addr 0x10, then read 0x10. Expect Stall high for 2 cycles on each access. Done pulses after edge k+2, and MDRdata=0x5A after the read.
- W=2: hold MemRead=1 at Addr 0x10 for 8 cycles. Expect accepts on edges 0, 3 and 6; Stall pattern 1,1,0 repeating; Done pulse every 3 cycles.
- MemRead=1 and MemWrite=1 together at IDLE. Expect BadReq=1 for one cycle, Stall=0, Done=0, store unchanged, MDRdata unchanged.
- W=3: write 0xFF to 0x20, then assert reset during the second BUSY cycle. Expect Stall=0 immediately and Done never pulses. A later read of 0x20 returns the prior value.
- W=0: write 0x33 to 0x01, then read 0x01. Expect Stall never high, Done one cycle after each accept, and MDRdata=0x33.
- W=2: write 0xA5 to address 0xFF, write 0x11 to address 0x00, then read both. Expect 0xA5 and 0x11 with no aliasing at the wrap-around boundary.
